// File: rtl/move_reader.sv
// Console move reader: prints a prompt, collects one echoed digit (optionally
// confirmed by CR) and hands the move to the game FSM as a one-cycle strobe.
module move_reader #(
   parameter bit ECHO       = 1'b1,
   parameter bit REQUIRE_CR = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_need_input,
   input  logic       i_rx_stb,
   input  logic [7:0] i_rx_data,
   input  logic       i_tx_busy,
   output logic       o_tx_stb,
   output logic [7:0] o_tx_data,
   output logic       o_busy,
   output logic [3:0] o_move,
   output logic       o_move_stb
);

   typedef enum logic [3:0] {
      S_IDLE, S_PROMPT, S_WAIT_KEY, S_ECHO, S_WAIT_CR,
      S_BSPACE, S_NEWLINE, S_STROBE, S_HOLD
   } state_t;

   state_t     state_q, state_d, tx_done_state;
   logic [2:0] idx_q, idx_d;
   logic       gap_q, gap_d;
   logic [3:0] move_q, move_d;
   logic [2:0] tx_len;
   logic [7:0] tx_byte;
   logic       tx_stb;
   logic       is_digit;

   assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);

   // Byte source for every transmitting state: length of the string and the
   // byte at the current index.
   always_comb begin
      tx_len        = 3'd0;
      tx_byte       = 8'h00;
      tx_done_state = S_IDLE;
      case (state_q)
         S_PROMPT: begin
            tx_len        = 3'd6;
            tx_done_state = S_WAIT_KEY;
            case (idx_q)
               3'd0:    tx_byte = 8'h4D;
               3'd1:    tx_byte = 8'h6F;
               3'd2:    tx_byte = 8'h76;
               3'd3:    tx_byte = 8'h65;
               3'd4:    tx_byte = 8'h3F;
               default: tx_byte = 8'h20;
            endcase
         end
         S_ECHO: begin
            tx_len        = ECHO ? 3'd1 : 3'd0;
            tx_byte       = {4'h3, move_q};
            tx_done_state = REQUIRE_CR ? S_WAIT_CR : S_NEWLINE;
         end
         S_BSPACE: begin
            tx_len        = ECHO ? 3'd3 : 3'd0;
            tx_byte       = (idx_q == 3'd1) ? 8'h20 : 8'h08;
            tx_done_state = S_WAIT_KEY;
         end
         S_NEWLINE: begin
            tx_len        = 3'd2;
            tx_byte       = (idx_q == 3'd0) ? 8'h0D : 8'h0A;
            tx_done_state = S_STROBE;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      move_d  = move_q;
      tx_stb  = 1'b0;
      case (state_q)
         S_IDLE:
            if (i_need_input) state_d = S_PROMPT;
         S_PROMPT, S_ECHO, S_BSPACE, S_NEWLINE: begin
            // A pending offer is withdrawn combinationally on abort, so no
            // byte can be taken in the abort cycle.
            if (!i_need_input) begin
               state_d = S_IDLE;
            end else if (idx_q == tx_len) begin
               state_d = tx_done_state;
            end else if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               tx_stb = 1'b1;
               if (!i_tx_busy) begin
                  idx_d = idx_q + 3'd1;
                  gap_d = 1'b1;
               end
            end
         end
         S_WAIT_KEY: begin
            if (!i_need_input) begin
               state_d = S_IDLE;
            end else if (i_rx_stb && is_digit) begin
               move_d = i_rx_data[3:0];
               if (ECHO)            state_d = S_ECHO;
               else if (REQUIRE_CR) state_d = S_WAIT_CR;
               else                 state_d = S_NEWLINE;
            end
         end
         S_WAIT_CR: begin
            if (!i_need_input) begin
               state_d = S_IDLE;
            end else if (i_rx_stb) begin
               if (i_rx_data == 8'h0D) begin
                  state_d = S_NEWLINE;
               end else if (i_rx_data == 8'h08 || i_rx_data == 8'h7F) begin
                  state_d = S_BSPACE;
               end else if (is_digit) begin
                  move_d  = i_rx_data[3:0];
                  state_d = ECHO ? S_ECHO : S_WAIT_CR;
               end
            end
         end
         S_STROBE:
            state_d = S_HOLD;
         S_HOLD:
            if (!i_need_input) state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         idx_d = 3'd0;
         gap_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         gap_q   <= 1'b0;
         move_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         move_q  <= move_d;
      end
   end

   assign o_tx_stb   = tx_stb;
   assign o_tx_data  = tx_stb ? tx_byte : 8'h00;
   assign o_busy     = (state_q == S_PROMPT) || (state_q == S_ECHO) ||
                       (state_q == S_BSPACE) || (state_q == S_NEWLINE);
   assign o_move     = move_q;
   assign o_move_stb = (state_q == S_STROBE);

endmodule
